// File: rtl/button_event_arbiter.sv
// Purpose: gathers one-cycle button press pulses into per-button pending flags and hands them out one at a time, round-robin.
// Latency: a press sampled at edge k sets pending at k+1 and raises evt_valid at k+2; one idle bubble follows each handshake.
// Backpressure: evt_valid/evt_id are held until evt_ready; new presses keep accumulating in pending and repeats raise sticky ovf bits.
module button_event_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [N-1:0]    press,
   output logic            evt_valid,
   output logic [ID_W-1:0] evt_id,
   input  logic            evt_ready,
   output logic [N-1:0]    pending,
   output logic [N-1:0]    ovf,
   input  logic            ovf_clr,
   output logic            busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      pending_q, pending_d;
   logic [N-1:0]      ovf_q, ovf_d;
   logic              evt_valid_q, evt_valid_d;
   logic [ID_W-1:0]   evt_id_q, evt_id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;

   logic [N-1:0]      set_mask;
   logic [N-1:0]      clr_mask;
   logic [N-1:0]      ovf_set;
   logic              sel_found;
   logic [ID_W-1:0]   sel_idx;
   logic [ID_W-1:0]   scan_idx;
   int                scan_pos;

   // Round-robin pick: first pending bit at or above ptr, wrapping from N-1 back to 0.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_pos  = 0;
      scan_idx  = '0;
      for (int k = 0; k < N; k++) begin
         scan_pos = (int'(ptr_q) + k) % N;
         scan_idx = ID_W'(scan_pos);
         if (!sel_found && pending_q[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   // Grant FSM: IDLE launches a grant when anything is pending, GRANT waits for the consumer.
   always_comb begin
      state_d     = state_q;
      evt_valid_d = evt_valid_q;
      evt_id_d    = evt_id_q;
      ptr_d       = ptr_q;
      clr_mask    = '0;
      case (state_q)
         IDLE: begin
            evt_valid_d = 1'b0;
            if (sel_found) begin
               state_d           = GRANT;
               evt_valid_d       = 1'b1;
               evt_id_d          = sel_idx;
               clr_mask[sel_idx] = 1'b1;
            end
         end
         GRANT: begin
            if (evt_ready) begin
               state_d     = IDLE;
               evt_valid_d = 1'b0;
               // Pointer wraps at N, not at 2^ID_W, so unused IDs are never visited.
               if (evt_id_q == ID_W'(N - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = evt_id_q + ID_W'(1);
               end
            end
         end
         default: begin
            state_d     = IDLE;
            evt_valid_d = 1'b0;
         end
      endcase
   end

   // Capture and overrun: a fresh press beats the grant-time clear, and only a press onto a
   // flag that is staying set counts as an overrun. A new overrun beats ovf_clr.
   always_comb begin
      set_mask  = en ? press : '0;
      ovf_set   = set_mask & pending_q & ~clr_mask;
      pending_d = (pending_q & ~clr_mask) | set_mask;
      ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_set;
   end

   // State and flag registers; reset abandons any in-flight grant without a handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         ovf_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         ovf_q       <= ovf_d;
         evt_valid_q <= evt_valid_d;
         evt_id_q    <= evt_id_d;
         ptr_q       <= ptr_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_id    = evt_id_q;
   assign pending   = pending_q;
   assign ovf       = ovf_q;
   assign busy      = (|pending_q) | evt_valid_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Purpose: directed checks of capture, round-robin grant order, overrun flags and async reset.
// Latency: grant order is scored by a monitor at every negedge handshake; cycle timing checked inline.
// Backpressure: evt_ready is held low in the overrun section to keep a grant outstanding.
module tb_button_event_arbiter;

   localparam int N    = 4;
   localparam int ID_W = 2;

   logic            clk;
   logic            rst;
   logic            en;
   logic [N-1:0]    press;
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic            evt_ready;
   logic [N-1:0]    pending;
   logic [N-1:0]    ovf;
   logic            ovf_clr;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;
   int exp_q[$];

   button_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .press     (press),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .pending   (pending),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
      end
   endtask

   // One-cycle press pulse, sampled at the next rising edge; returns just after that edge.
   task automatic pulse(input logic [N-1:0] m);
      press = m;
      @(posedge clk);
      #1 press = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Monitor: every accepted event must match the oldest expected grant.
   always @(negedge clk) begin
      if (rst && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_unexpected: got id %0d, want no grant", evt_id);
         end else begin
            chk("grant_id", 32'(evt_id), 32'(exp_q.pop_front()));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst       = 1'b0;
      en        = 1'b1;
      press     = '0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_valid", 32'(evt_valid), 32'h0);
      chk("rst_id", 32'(evt_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Single press on button 2: pending next cycle, grant the cycle after
      exp_q.push_back(2);
      pulse(4'b0100);
      @(negedge clk);
      chk("t1_pending", 32'(pending), 32'h4);
      chk("t1_valid_early", 32'(evt_valid), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("t1_valid", 32'(evt_valid), 32'h1);
      chk("t1_id", 32'(evt_id), 32'h2);
      chk("t1_pending_clr", 32'(pending), 32'h0);
      @(negedge clk);
      chk("t1_valid_done", 32'(evt_valid), 32'h0);
      chk("t1_busy_done", 32'(busy), 32'h0);
      idle(1);

      // All four at once: 0,1,2,3, one grant every second cycle
      do_reset();
      for (int i = 0; i < N; i++) exp_q.push_back(i);
      pulse(4'b1111);
      chk("t2_pending", 32'(pending), 32'hF);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         chk("t2_valid_cadence", 32'(evt_valid), (c % 2 == 0) ? 32'h1 : 32'h0);
      end
      chk("t2_busy_done", 32'(busy), 32'h0);
      idle(1);

      // Service button 1 (ptr -> 2), then 0 and 3 together: 3 first, then wrap to 0
      exp_q.push_back(1);
      pulse(4'b0010);
      idle(4);
      exp_q.push_back(3);
      exp_q.push_back(0);
      pulse(4'b1001);
      idle(6);

      // Press on the button being granted in the grant cycle: stays pending, no overrun
      exp_q.push_back(2);
      exp_q.push_back(2);
      pulse(4'b0100);
      pulse(4'b0100);
      @(negedge clk);
      chk("t3b_pending", 32'(pending), 32'h4);
      chk("t3b_ovf", 32'(ovf), 32'h0);
      chk("t3b_id", 32'(evt_id), 32'h2);
      idle(6);

      // Consumer stalled on button 1: re-press, overrun, clear, clear-vs-overrun
      evt_ready = 1'b0;
      exp_q.push_back(1);
      pulse(4'b0010);
      idle(1);
      @(negedge clk);
      chk("t4_valid", 32'(evt_valid), 32'h1);
      chk("t4_id", 32'(evt_id), 32'h1);
      chk("t4_pending0", 32'(pending), 32'h0);
      pulse(4'b0010);
      @(negedge clk);
      chk("t4_pending_repress", 32'(pending), 32'h2);
      chk("t4_ovf_none", 32'(ovf), 32'h0);
      pulse(4'b0010);
      @(negedge clk);
      chk("t4_ovf_set", 32'(ovf), 32'h2);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      @(negedge clk);
      chk("t4_ovf_cleared", 32'(ovf), 32'h0);
      pulse(4'b1000);
      @(negedge clk);
      chk("t4_pending_1010", 32'(pending), 32'hA);
      ovf_clr = 1'b1;
      pulse(4'b1000);
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("t4_ovf_clr_vs_ovr", 32'(ovf), 32'h8);
      chk("t4_id_held", 32'(evt_id), 32'h1);
      chk("t4_valid_held", 32'(evt_valid), 32'h1);

      // Asynchronous reset mid-grant: everything clears at once
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_pending", 32'(pending), 32'h0);
      chk("t6_ovf", 32'(ovf), 32'h0);
      chk("t6_valid", 32'(evt_valid), 32'h0);
      chk("t6_id", 32'(evt_id), 32'h0);
      chk("t6_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      evt_ready = 1'b1;

      // Capture disabled: press is ignored
      en = 1'b0;
      pulse(4'b0001);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t5_pending", 32'(pending), 32'h0);
         chk("t5_ovf", 32'(ovf), 32'h0);
         chk("t5_valid", 32'(evt_valid), 32'h0);
      end
      en = 1'b1;

      // Pointer was reset to 0: 0 before 3, then a lone press on 3
      exp_q.push_back(0);
      exp_q.push_back(3);
      pulse(4'b1001);
      idle(6);
      exp_q.push_back(3);
      pulse(4'b1000);
      @(negedge clk);
      chk("t7_pending", 32'(pending), 32'h8);
      @(negedge clk);
      chk("t7_valid", 32'(evt_valid), 32'h1);
      chk("t7_id", 32'(evt_id), 32'h3);
      idle(3);

      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects single-cycle press pulses from N pushbutton detector channels.
- Holds one pending flag per button.
- Grants pending events to a single consumer, one at a time, in round-robin order over a valid/ready handshake.
- Flags overruns, where a press arrives while the previous press on that button is still unserviced.
- Sits between the per-button detect chains and the control FSM that acts on button commands.

Parameters:
- N, 4, number of button channels (2..8).
- ID_W, 2, width of event ID; 2^ID_W >= N is required.

Ports:
- clk, input, 1, system clock; same clock that drives the press pulses.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, press capture enable; 0 = incoming presses ignored.
- press, input, N, one-cycle press pulses, already synchronous to clk, bit i = button i.
- evt_valid, output, 1, event available.
- evt_id, output, ID_W, index of the granted button; stable while evt_valid=1.
- evt_ready, input, 1, consumer accepts the event.
- pending, output, N, current pending flags.
- ovf, output, N, sticky overrun flags.
- ovf_clr, input, 1, clears all ovf bits.
- busy, output, 1, high when any pending bit is set or evt_valid=1.

Behaviour:

Reset:
- rst=0 asynchronously clears pending, ovf, evt_valid, evt_id and rr pointer (ptr=0).
- State returns to IDLE.
- Reset mid-grant drops the event with no handshake.

Capture:
- On a clk edge with en=1 and press[i]=1, pending[i] <= 1.
- With en=0, press is ignored entirely: no pending set, no ovf set.

Overrun:
- press[i]=1, en=1, and pending[i] already 1 and not being cleared this cycle: ovf[i] <= 1.
- A granted-but-unaccepted event counts as cleared. A press on the granted button while evt_valid=1 sets pending[i] and does not set ovf.
- ovf bits are sticky until ovf_clr=1, which clears all bits in one cycle.
- ovf_clr and a new overrun in the same cycle: the overrun wins (bit stays 1).

FSM, two states:
- IDLE:
  - If pending != 0, select the first set bit searching upward from ptr, wrapping N-1 -> 0.
  - evt_id <= sel, evt_valid <= 1, pending[sel] <= 0 (unless a new press on sel arrives this cycle, in which case pending[sel] stays 1).
  - Go to GRANT.
  - If pending == 0, stay in IDLE with evt_valid=0.
- GRANT:
  - Hold evt_valid=1 and evt_id constant until evt_ready=1.
  - On evt_valid & evt_ready: evt_valid <= 0, ptr <= (evt_id+1) mod N, go to IDLE.
  - evt_ready while in IDLE is ignored.

Latency:
- Press at edge k -> pending at k+1 -> evt_valid at k+2.
- After a handshake there is one bubble cycle (IDLE) before the next grant, so throughput is at most 1 event per 2 cycles.

Other rules:
- busy = |pending | evt_valid, combinational from registers.
- ptr arithmetic is mod N, not mod 2^ID_W. Bits above N-1 do not exist.
- No glitching: all outputs except busy are registered.

Test Plan:
- Reset, then single press[2] with evt_ready tied 1 -> evt_valid=1, evt_id=2 exactly 2 cycles after the press; pending returns to 0; busy falls after the handshake.
- press=4'b1111 in one cycle, evt_ready=1 -> events granted in order 0,1,2,3, one every 2 cycles; ptr wraps to 0.
- ptr=2 (after servicing button 1), then press buttons 0 and 3 together -> grant order 3 then 0 (round-robin wrap).
- evt_ready held 0 with evt_id=1 granted; press[1] again -> pending[1]=1, ovf[1]=0. Press[1] once more -> ovf[1]=1. Assert ovf_clr -> ovf=0. Assert ovf_clr together with another overrun on button 3 -> ovf[3]=1.
- en=0, pulse press[0] -> pending and ovf unchanged, evt_valid stays 0.
- Assert rst=0 asynchronously while evt_valid=1 with pending=4'b1010 -> all outputs 0 immediately. After release, a press[3] is granted normally with the search starting at ptr=0.
